id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter data_width, default 32, datapath width.
REQ-002 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-004 SHALL have port stall  in  1  hold all stage state.
REQ-005 SHALL have port flush  in  1  kill the stage contents (taken branch).
REQ-006 SHALL have port id_valid  in  1  ID holds a real instruction.
REQ-007 SHALL have port id_rs1_data  in  data_width  register-file read port 1.
REQ-008 SHALL have port id_rs2_data  in  data_width  register-file read port 2.
REQ-009 SHALL have port id_imm  in  data_width  sign-extended immediate.
REQ-010 SHALL have ports id_rs1, id_rs2, id_rd  in  5 each  register indices.
REQ-011 SHALL have ports id_funct3 (3), id_funct7 (7), id_alu_op (2)  in  ALU decode fields.
REQ-012 SHALL have port id_alu_src  in  1  1 = operand B from immediate.
REQ-013 SHALL have port id_ctrl  in  4  {reg_write, mem_read, mem_write, mem_to_reg}.
REQ-014 SHALL have ports exmem_reg_write (1), exmem_rd (5), exmem_result (data_width)  in  EX/MEM forward source.
REQ-015 SHALL have ports memwb_reg_write (1), memwb_rd (5), memwb_result (data_width)  in  MEM/WB forward source.
REQ-016 SHALL have port ex_valid  out  1  EX holds a real instruction.
REQ-017 SHALL have ports ex_operand_A, ex_operand_B  out  data_width  ALU operands.
REQ-018 SHALL have port ex_store_data  out  data_width  forwarded rs2 for stores.
REQ-019 SHALL have ports ex_funct3 (3), ex_funct7 (7), ex_alu_op (2), ex_rd (5), ex_ctrl (4)  out  registered fields.
REQ-020 SHALL have port load_use_hazard  out  1  request IF/ID stall.

Function
REQ-021 SHALL register all id_* fields plus id_rs1/id_rs2 on clk; one-cycle latency ID to EX.
REQ-022 SHALL update on each edge by priority: rst > flush > stall > load_use_hazard > capture.
REQ-023 SHALL, on flush or load_use_hazard (no stall), load a bubble: ex_valid, ex_ctrl, all registered fields and data 0.
REQ-024 SHALL, on stall, hold every register unchanged; a held load keeps load_use_hazard asserted.
REQ-025 SHALL drive load_use_hazard = ex_valid & ex_ctrl.mem_read & ex_rd!=0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd), combinationally.
REQ-026 SHALL forward combinationally per source register r (rs1, rs2): exmem_result if exmem_reg_write & exmem_rd==r & r!=0; else memwb_result if memwb_reg_write & memwb_rd==r & r!=0; else registered data.
REQ-027 SHALL give EX/MEM priority over MEM/WB when both match.
REQ-028 SHALL never forward to x0; r==0 always yields registered data.
REQ-029 SHALL drive ex_operand_A = forwarded rs1; ex_operand_B = registered alu_src ? registered imm : forwarded rs2.
REQ-030 SHALL drive ex_store_data = forwarded rs2 regardless of alu_src.
REQ-031 SHALL treat register-file same-cycle write/read as the register file's responsibility; the stage adds no ID-side bypass.
REQ-032 SHALL capture a bubble when id_valid=0, irrespective of other id_* inputs.

Reset
REQ-033 SHALL, with rst high at an edge, clear all registers to 0 (ex_valid=0, ex_ctrl=0) regardless of stall/flush.
REQ-034 SHALL, after rst mid-stream, emit load_use_hazard=0 and forward no stale EX state.

Verification
REQ-035 Capture: id rs1_data=5, rs2_data=7, alu_op=10, ctrl=1000, no fwd -> next cycle ex_operand_A=5, B=7, ex_ctrl=1000, ex_valid=1.
REQ-036 Forward priority: ex rs1=3, exmem_rd=3 result=0xAA, memwb_rd=3 result=0xBB, both write -> ex_operand_A=0xAA; exmem_reg_write=0 -> 0xBB.
REQ-037 x0: ex rs1=0, exmem_rd=0 reg_write=1 result=0xFF -> ex_operand_A = registered rs1_data.
REQ-038 Load-use: EX holds lw rd=4, ID rs2=4 -> load_use_hazard=1, next cycle ex_valid=0, ex_ctrl=0.
REQ-039 Priority: stall=1 with flush=0 and hazard -> state held, hazard stays 1; flush=1 with stall=1 -> bubble; rst=1 with flush=1 -> all 0.
REQ-040 Immediate: alu_src=1, imm=0xFFFFFFF0, rs2 forwarded 0x12 -> ex_operand_B=0xFFFFFFF0, ex_store_data=0x12.

Source files
------------

// File: rtl/id_ex_if.sv
// ID/EX pipeline-stage bundle: decode-side inputs, forwarding sources, and EX-side outputs.
// The stage itself takes the slave view; whoever drives decode and observes EX takes master.
interface id_ex_if #(
    parameter int unsigned data_width = 32
);
    logic                  stall;
    logic                  flush;
    logic                  id_valid;
    logic [data_width-1:0] id_rs1_data;
    logic [data_width-1:0] id_rs2_data;
    logic [data_width-1:0] id_imm;
    logic [4:0]            id_rs1;
    logic [4:0]            id_rs2;
    logic [4:0]            id_rd;
    logic [2:0]            id_funct3;
    logic [6:0]            id_funct7;
    logic [1:0]            id_alu_op;
    logic                  id_alu_src;
    logic [3:0]            id_ctrl;

    logic                  exmem_reg_write;
    logic [4:0]            exmem_rd;
    logic [data_width-1:0] exmem_result;
    logic                  memwb_reg_write;
    logic [4:0]            memwb_rd;
    logic [data_width-1:0] memwb_result;

    logic                  ex_valid;
    logic [data_width-1:0] ex_operand_A;
    logic [data_width-1:0] ex_operand_B;
    logic [data_width-1:0] ex_store_data;
    logic [2:0]            ex_funct3;
    logic [6:0]            ex_funct7;
    logic [1:0]            ex_alu_op;
    logic [4:0]            ex_rd;
    logic [3:0]            ex_ctrl;
    logic                  load_use_hazard;

    modport master (
        output stall, flush, id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_funct3, id_funct7, id_alu_op, id_alu_src, id_ctrl,
               exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
        input  ex_valid, ex_operand_A, ex_operand_B, ex_store_data, ex_funct3, ex_funct7,
               ex_alu_op, ex_rd, ex_ctrl, load_use_hazard
    );

    modport slave (
        input  stall, flush, id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_funct3, id_funct7, id_alu_op, id_alu_src, id_ctrl,
               exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
        output ex_valid, ex_operand_A, ex_operand_B, ex_store_data, ex_funct3, ex_funct7,
               ex_alu_op, ex_rd, ex_ctrl, load_use_hazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
// Update priority on each edge: rst > flush > stall > load-use bubble > capture.
module id_ex_stage #(
    parameter int unsigned data_width = 32
) (
    input logic    clk,
    input logic    rst,
    id_ex_if.slave bus
);
    // ctrl bit order: {reg_write, mem_read, mem_write, mem_to_reg}
    typedef struct packed {
        logic                  valid;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic [1:0]            alu_op;
        logic                  alu_src;
        logic [3:0]            ctrl;
        logic [data_width-1:0] rs1_data;
        logic [data_width-1:0] rs2_data;
        logic [data_width-1:0] imm;
    } stage_t;

    stage_t                stage_q, stage_d;
    logic                  hazard;
    logic [data_width-1:0] fwd_rs1, fwd_rs2;

    always_comb begin
        hazard = stage_q.valid & stage_q.ctrl[2] & (stage_q.rd != 5'd0) & bus.id_valid &
                 ((bus.id_rs1 == stage_q.rd) | (bus.id_rs2 == stage_q.rd));
    end

    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d = '0;
        end else if (bus.stall) begin
            stage_d = stage_q;
        end else if (hazard || !bus.id_valid) begin
            stage_d = '0;
        end else begin
            stage_d.valid    = 1'b1;
            stage_d.rs1      = bus.id_rs1;
            stage_d.rs2      = bus.id_rs2;
            stage_d.rd       = bus.id_rd;
            stage_d.funct3   = bus.id_funct3;
            stage_d.funct7   = bus.id_funct7;
            stage_d.alu_op   = bus.id_alu_op;
            stage_d.alu_src  = bus.id_alu_src;
            stage_d.ctrl     = bus.id_ctrl;
            stage_d.rs1_data = bus.id_rs1_data;
            stage_d.rs2_data = bus.id_rs2_data;
            stage_d.imm      = bus.id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // The younger EX/MEM result wins over MEM/WB; x0 is never a forwarding target.
    always_comb begin
        fwd_rs1 = stage_q.rs1_data;
        if (bus.exmem_reg_write && bus.exmem_rd == stage_q.rs1 && stage_q.rs1 != 5'd0) begin
            fwd_rs1 = bus.exmem_result;
        end else if (bus.memwb_reg_write && bus.memwb_rd == stage_q.rs1 &&
                     stage_q.rs1 != 5'd0) begin
            fwd_rs1 = bus.memwb_result;
        end
    end

    always_comb begin
        fwd_rs2 = stage_q.rs2_data;
        if (bus.exmem_reg_write && bus.exmem_rd == stage_q.rs2 && stage_q.rs2 != 5'd0) begin
            fwd_rs2 = bus.exmem_result;
        end else if (bus.memwb_reg_write && bus.memwb_rd == stage_q.rs2 &&
                     stage_q.rs2 != 5'd0) begin
            fwd_rs2 = bus.memwb_result;
        end
    end

    assign bus.ex_valid        = stage_q.valid;
    assign bus.ex_operand_A    = fwd_rs1;
    assign bus.ex_operand_B    = stage_q.alu_src ? stage_q.imm : fwd_rs2;
    assign bus.ex_store_data   = fwd_rs2;
    assign bus.ex_funct3       = stage_q.funct3;
    assign bus.ex_funct7       = stage_q.funct7;
    assign bus.ex_alu_op       = stage_q.alu_op;
    assign bus.ex_rd           = stage_q.rd;
    assign bus.ex_ctrl         = stage_q.ctrl;
    assign bus.load_use_hazard = hazard;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage: each record drives one cycle of inputs and
// lists the EX-side values expected just after the following rising edge.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    id_ex_if #(.data_width(32)) bus ();

    id_ex_stage #(.data_width(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // misc packs {funct7, funct3, alu_op, rd} for both stimulus and expectation.
    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        id_valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [16:0] misc;
        logic        alu_src;
        logic [3:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic        e_v;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_sd;
        logic [3:0]  e_ctrl;
        logic [16:0] e_misc;
        logic        e_hz;
    } vec_t;

    localparam int NumVec = 17;
    vec_t tbl [NumVec];
    vec_t hv;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall           = v.stall;
        bus.flush           = v.flush;
        bus.id_valid        = v.id_valid;
        bus.id_rs1          = v.rs1;
        bus.id_rs2          = v.rs2;
        bus.id_funct7       = v.misc[16:10];
        bus.id_funct3       = v.misc[9:7];
        bus.id_alu_op       = v.misc[6:5];
        bus.id_rd           = v.misc[4:0];
        bus.id_alu_src      = v.alu_src;
        bus.id_ctrl         = v.ctrl;
        bus.id_rs1_data     = v.d1;
        bus.id_rs2_data     = v.d2;
        bus.id_imm          = v.imm;
        bus.exmem_reg_write = v.xw;
        bus.exmem_rd        = v.xrd;
        bus.exmem_result    = v.xres;
        bus.memwb_reg_write = v.ww;
        bus.memwb_rd        = v.wrd;
        bus.memwb_result    = v.wres;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(v.e_v));
        check({tag, ".opA"}, bus.ex_operand_A, v.e_a);
        check({tag, ".opB"}, bus.ex_operand_B, v.e_b);
        check({tag, ".store"}, bus.ex_store_data, v.e_sd);
        check({tag, ".ex_ctrl"}, 32'(bus.ex_ctrl), 32'(v.e_ctrl));
        check({tag, ".misc"}, 32'({bus.ex_funct7, bus.ex_funct3, bus.ex_alu_op, bus.ex_rd}),
              32'(v.e_misc));
        check({tag, ".hazard"}, 32'(bus.load_use_hazard), 32'(v.e_hz));
    endtask

    initial begin
        // stall, flush, id_valid, rs1, rs2, misc, alu_src, ctrl, d1, d2, imm,
        // xw, xrd, xres, ww, wrd, wres | e_v, e_a, e_b, e_sd, e_ctrl, e_misc, e_hz
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 17'h00045, 1'b0, 4'h8, 32'h5, 32'h7, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h5, 32'h7, 32'h7, 4'h8, 17'h00045, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 5'd3, 5'd6, 17'h082C7, 1'b0, 4'h8, 32'h11, 32'h22, 32'h0,
                    1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB,
                    1'b1, 32'hAA, 32'h22, 32'h22, 4'h8, 17'h082C7, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 5'd9, 5'd9, 17'h00041, 1'b0, 4'h8, 32'h99, 32'h99, 32'h0,
                    1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB,
                    1'b1, 32'hBB, 32'h22, 32'h22, 4'h8, 17'h082C7, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 17'h00041, 1'b0, 4'h8, 32'h33, 32'h44, 32'h0,
                    1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE,
                    1'b1, 32'h33, 32'h44, 32'h44, 4'h8, 17'h00041, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 17'h00044, 1'b1, 4'hD, 32'h100, 32'h0, 32'h8,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h100, 32'h8, 32'h0, 4'hD, 17'h00044, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 5'd0, 5'd4, 17'h00046, 1'b0, 4'h8, 32'h1, 32'h2, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h100, 32'h8, 32'h0, 4'hD, 17'h00044, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 5'd0, 5'd4, 17'h00046, 1'b0, 4'h8, 32'h1, 32'h2, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 17'h00000, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 5'd0, 5'd4, 17'h00046, 1'b0, 4'h8, 32'h1, 32'h2, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h1234,
                    1'b1, 32'h1, 32'h1234, 32'h1234, 4'h8, 17'h00046, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 5'd5, 5'd6, 17'h00048, 1'b1, 4'h8, 32'h50, 32'h60,
                    32'hFFFFFFF0, 1'b1, 5'd6, 32'h12, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h50, 32'hFFFFFFF0, 32'h12, 4'h8, 17'h00048, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 5'd3, 5'd3, 17'h1FFFF, 1'b1, 4'hF, 32'hDEAD, 32'hDEAD,
                    32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 17'h00000, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 5'd2, 5'd3, 17'h00049, 1'b0, 4'hD, 32'h20, 32'h30, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h20, 32'h30, 32'h30, 4'hD, 17'h00049, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 17'h0004B, 1'b0, 4'h8, 32'h1, 32'h1, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 17'h00000, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 17'h00040, 1'b0, 4'hD, 32'h3, 32'h4, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h3, 32'h4, 32'h4, 4'hD, 17'h00040, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 17'h00041, 1'b0, 4'h8, 32'h0, 32'h0, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h3, 32'h4, 32'h4, 4'hD, 17'h00040, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 17'h0004A, 1'b0, 4'hD, 32'h7, 32'h8, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h7, 32'h8, 32'h8, 4'hD, 17'h0004A, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 5'd10, 5'd0, 17'h00041, 1'b0, 4'h8, 32'h0, 32'h0, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h7, 32'h8, 32'h8, 4'hD, 17'h0004A, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 5'd10, 5'd0, 17'h00041, 1'b0, 4'h8, 32'h0, 32'h0, 32'h0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h7, 32'h8, 32'h8, 4'hD, 17'h0004A, 1'b1};

        // Reset held across two edges with stall asserted.
        hv = '0;
        hv.stall = 1'b1;
        drive(hv);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", hv);
        rst = 1'b0;

        for (int i = 0; i < NumVec; i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i]);
        end

        // EX holds lw rd=10: hazard must be visible before the edge, then a bubble follows.
        hv = '0;
        hv.id_valid = 1'b1;
        hv.rs2      = 5'd10;
        hv.misc     = 17'h0004B;
        hv.ctrl     = 4'h8;
        drive(hv);
        #1;
        check("luh_pre_edge", 32'(bus.load_use_hazard), 32'h1);
        @(posedge clk);
        #1;
        check("luh_bubble.ex_valid", 32'(bus.ex_valid), 32'h0);
        check("luh_bubble.ex_ctrl", 32'(bus.ex_ctrl), 32'h0);

        // Load a lw rd=4, then reset together with flush and stall while a hazard is pending.
        hv = '0;
        hv.id_valid = 1'b1;
        hv.misc     = 17'h00044;
        hv.ctrl     = 4'hD;
        hv.d1       = 32'h55;
        drive(hv);
        @(posedge clk);
        #1;
        check("lw4.ex_valid", 32'(bus.ex_valid), 32'h1);
        hv.rs1   = 5'd4;
        hv.stall = 1'b1;
        hv.flush = 1'b1;
        hv.xw    = 1'b1;
        hv.xres  = 32'hFF;
        drive(hv);
        #1;
        check("lw4.hazard_pre", 32'(bus.load_use_hazard), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        hv.e_v    = 1'b0;
        hv.e_a    = 32'h0;
        hv.e_b    = 32'h0;
        hv.e_sd   = 32'h0;
        hv.e_ctrl = 4'h0;
        hv.e_misc = 17'h0;
        hv.e_hz   = 1'b0;
        check_all("rst_mid", hv);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
